// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Holds the FSM state encoding, status bit positions and default bus addresses.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   localparam logic [31:0] DEF_TX_DATA_ADDR = 32'h0000_03f0;
   localparam logic [31:0] DEF_TX_STAT_ADDR = 32'h0000_03f4;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// CPU data-bus view of the UART peripheral: address, store data/strobe, read data and hit.
// The CPU side is the master; the peripheral answers combinationally.
interface uart_tx_mmio_if;
   logic [31:0] rw_addr;
   logic [31:0] w_data;
   logic        w_en;
   logic [31:0] r_data;
   logic        hit;

   modport master (output rw_addr, output w_data, output w_en, input r_data, input hit);
   modport slave  (input rw_addr, input w_data, input w_en, output r_data, output hit);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, head shown combinationally on dout; one-cycle write-to-visible latency.
// The caller must gate push when full (unless popping) and never pop when empty.
module sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= din;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores to the data address queue bytes, status is polled.
// tx falls one edge after the push edge; bytes stored while the FIFO is full are dropped and flagged.
module uart_tx_mmio
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] TX_DATA_ADDR = DEF_TX_DATA_ADDR,
   parameter logic [31:0] TX_STAT_ADDR = DEF_TX_STAT_ADDR
) (
   input  logic           clock,
   input  logic           reset_n,
   uart_tx_mmio_if.slave  bus,
   output logic           tx
);

   localparam int            TW     = $clog2(CLKS_PER_BIT);
   localparam int            CW     = $clog2(FIFO_DEPTH) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

   tx_state_t     state, state_n;
   logic [TW-1:0] timer, timer_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic          tx_n;
   logic          overflow;

   logic          fifo_pop, fifo_full, fifo_empty;
   logic [7:0]    fifo_dout;
   logic [CW-1:0] fifo_count;
   logic          push_req, push_ok, drop, stat_wr;
   logic [31:0]   status;
   logic          unused_wdata_hi;

   assign push_req        = bus.w_en && (bus.rw_addr == TX_DATA_ADDR);
   assign stat_wr         = bus.w_en && (bus.rw_addr == TX_STAT_ADDR);
   assign push_ok         = push_req && (!fifo_full || fifo_pop);
   assign drop            = push_req && !push_ok;
   assign unused_wdata_hi = ^bus.w_data[31:8];

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clock   (clock),
      .reset_n (reset_n),
      .push    (push_ok),
      .pop     (fifo_pop),
      .din     (bus.w_data[7:0]),
      .dout    (fifo_dout),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_comb begin
      state_n   = state;
      timer_n   = timer + 1'b1;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      tx_n      = tx;
      fifo_pop  = 1'b0;
      case (state)
         IDLE: begin
            timer_n = '0;
            tx_n    = 1'b1;
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               shreg_n  = fifo_dout;
               state_n  = START;
               tx_n     = 1'b0;
            end
         end
         START: begin
            if (timer == T_LAST) begin
               timer_n   = '0;
               bit_idx_n = '0;
               state_n   = DATA;
               tx_n      = shreg[0];
            end
         end
         DATA: begin
            if (timer == T_LAST) begin
               timer_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  // shreg[0] is always the bit currently on the line
                  bit_idx_n = bit_idx + 1'b1;
                  shreg_n   = {1'b0, shreg[7:1]};
                  tx_n      = shreg[1];
               end
            end
         end
         STOP: begin
            if (timer == T_LAST) begin
               timer_n = '0;
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  shreg_n  = fifo_dout;
                  state_n  = START;
                  tx_n     = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = '0;
            tx_n    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state    <= IDLE;
         timer    <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         tx       <= 1'b1;
         overflow <= 1'b0;
      end else begin
         state   <= state_n;
         timer   <= timer_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         tx      <= tx_n;
         if (drop)
            overflow <= 1'b1;
         else if (stat_wr)
            overflow <= 1'b0;
      end
   end

   always_comb begin
      status                     = '0;
      status[ST_BUSY]            = (state != IDLE);
      status[ST_FULL]            = fifo_full;
      status[ST_EMPTY]           = fifo_empty;
      status[ST_OVF]             = overflow;
      status[ST_CNT_LSB +: CW]   = fifo_count;
   end

   assign bus.hit    = (bus.rw_addr == TX_DATA_ADDR) || (bus.rw_addr == TX_STAT_ADDR);
   assign bus.r_data = (bus.rw_addr == TX_STAT_ADDR) ? status : 32'h0;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: stores queue expected bytes, a serial monitor decodes frames
// and checks them against the queue; status reads are checked against hand-computed words.
module tb_uart_tx_mmio;
   import uart_pkg::*;

   localparam int CPB = 4;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic tx;

   uart_tx_mmio_if bus();

   uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus),
      .tx      (tx)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   int         starts[$];
   int         rx_done = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic store(input logic [31:0] addr, input logic [7:0] data);
      bus.rw_addr = addr;
      bus.w_data  = {24'h0, data};
      bus.w_en    = 1'b1;
      @(posedge clock);
      #1;
      bus.w_en    = 1'b0;
   endtask

   task automatic peek(input logic [31:0] addr);
      bus.rw_addr = addr;
      bus.w_en    = 1'b0;
      #1;
   endtask

   task automatic stat(input string name, input logic [31:0] exp);
      peek(DEF_TX_STAT_ADDR);
      chk(name, bus.r_data, exp);
   endtask

   task automatic wait_rx(input int target, input int budget);
      int n = 0;
      while (rx_done < target && n < budget) begin
         @(posedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      chk("rx_timeout", 32'(rx_done >= target), 32'd1);
   endtask

   // Serial monitor: samples tx every negedge, a frame is 40 samples starting at the first low one.
   initial begin : monitor
      logic       s [0:39];
      logic [7:0] b;
      bit         shape_ok;
      bit         aborted;
      forever begin
         @(negedge clock);
         if (reset_n && tx === 1'b0) begin
            starts.push_back(cyc);
            s[0]    = tx;
            aborted = 1'b0;
            for (int k = 1; k < 40; k++) begin
               @(negedge clock);
               if (!reset_n) begin
                  aborted = 1'b1;
                  break;
               end
               s[k] = tx;
            end
            if (!aborted) begin
               shape_ok = 1'b1;
               for (int k = 0; k < 40; k++)
                  if (s[k] !== s[(k / 4) * 4]) shape_ok = 1'b0;
               if (s[0] !== 1'b0 || s[36] !== 1'b1) shape_ok = 1'b0;
               for (int i = 0; i < 8; i++)
                  b[i] = s[4 + 4 * i];
               chk("frame_shape", 32'(shape_ok), 32'd1);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_frame actual=%h expected=none", b);
               end else begin
                  chk("frame_data", {24'h0, b}, {24'h0, exp_q.pop_front()});
               end
               rx_done++;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int e, c2, rx0, mx;
      bus.rw_addr = 32'h0;
      bus.w_data  = 32'h0;
      bus.w_en    = 1'b0;
      reset_n     = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      reset_n = 1'b1;

      // Reset state and address decode
      chk("t1_tx_idle", {31'h0, tx}, 32'd1);
      peek(DEF_TX_STAT_ADDR);
      chk("t1_stat", bus.r_data, 32'h4);
      chk("t1_hit_stat", {31'h0, bus.hit}, 32'd1);
      peek(32'h0000_03fc);
      chk("t1_hit_other", {31'h0, bus.hit}, 32'd0);
      chk("t1_rdata_other", bus.r_data, 32'h0);

      // Single byte
      starts.delete();
      exp_q.push_back(8'h55);
      store(DEF_TX_DATA_ADDR, 8'h55);
      e = cyc;
      stat("t2_after_push", 32'h100);
      @(posedge clock);
      #1;
      stat("t2_busy", 32'h5);
      wait_rx(1, 200);
      chk("t2_start_latency", starts.size() > 0 ? starts[0] : -1, e + 1);
      repeat (2) @(posedge clock);
      #1;
      stat("t2_idle", 32'h4);

      // Back-to-back frames
      rx0 = rx_done;
      starts.delete();
      mx  = 0;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h0F);
      exp_q.push_back(8'hFF);
      store(DEF_TX_DATA_ADDR, 8'hA5);
      peek(DEF_TX_STAT_ADDR);
      if (int'(bus.r_data[11:8]) > mx) mx = int'(bus.r_data[11:8]);
      store(DEF_TX_DATA_ADDR, 8'h0F);
      peek(DEF_TX_STAT_ADDR);
      if (int'(bus.r_data[11:8]) > mx) mx = int'(bus.r_data[11:8]);
      store(DEF_TX_DATA_ADDR, 8'hFF);
      for (int i = 0; i < 130; i++) begin
         peek(DEF_TX_STAT_ADDR);
         if (int'(bus.r_data[11:8]) > mx) mx = int'(bus.r_data[11:8]);
         @(posedge clock);
         #1;
      end
      wait_rx(rx0 + 3, 200);
      chk("t3_count_peak", mx, 2);
      chk("t3_gap_1", starts.size() > 2 ? starts[1] - starts[0] : -1, 40);
      chk("t3_gap_2", starts.size() > 2 ? starts[2] - starts[1] : -1, 40);
      stat("t3_idle", 32'h4);

      // Overflow, clear, drop after clear, push on a full-FIFO pop edge
      rx0 = rx_done;
      for (int i = 0; i < 9; i++)
         exp_q.push_back(8'(i));
      store(DEF_TX_DATA_ADDR, 8'h00);
      store(DEF_TX_DATA_ADDR, 8'h01);
      c2 = cyc;
      for (int i = 2; i < 10; i++)
         store(DEF_TX_DATA_ADDR, 8'(i));
      stat("t4_overflow", 32'h80B);
      store(DEF_TX_STAT_ADDR, 8'h00);
      stat("t5_cleared", 32'h803);
      store(DEF_TX_DATA_ADDR, 8'hEE);
      stat("t5_drop_sets", 32'h80B);
      store(DEF_TX_STAT_ADDR, 8'h00);
      stat("t5_cleared_again", 32'h803);
      while (cyc < c2 + 39) begin
         @(posedge clock);
         #1;
      end
      stat("t5_before_pop_edge", 32'h803);
      exp_q.push_back(8'h77);
      store(DEF_TX_DATA_ADDR, 8'h77);
      stat("t5_push_on_pop", 32'h803);
      wait_rx(rx0 + 10, 700);
      stat("t5_idle", 32'h4);

      // Reset during DATA bit 3 with two bytes still queued
      rx0 = rx_done;
      store(DEF_TX_DATA_ADDR, 8'h11);
      store(DEF_TX_DATA_ADDR, 8'h22);
      c2 = cyc;
      store(DEF_TX_DATA_ADDR, 8'h33);
      stat("t6_queued", 32'h201);
      while (cyc < c2 + 16) begin
         @(posedge clock);
         #1;
      end
      chk("t6_tx_bit3", {31'h0, tx}, 32'd0);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      chk("t6_tx_after_reset", {31'h0, tx}, 32'd1);
      stat("t6_stat_reset", 32'h4);
      reset_n = 1'b1;
      repeat (150) @(posedge clock);
      #1;
      chk("t6_tx_quiet", {31'h0, tx}, 32'd1);
      stat("t6_stat_quiet", 32'h4);
      chk("t6_no_frames", rx_done, rx0);

      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter peripheral on the CPU data-memory bus, alongside `data_mem` and the LED driver. The CPU writes bytes with store instructions. The block buffers them in a small FIFO and serializes them as 8N1 frames on `tx`. A status word is readable at a second address so software can poll for space or completion, the same way it polls the LED status register. The top level routes `r_data` into the load-data mux whenever `hit` is high.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit. Minimum 2.
- `FIFO_DEPTH`, 8: byte FIFO depth. Power of two, at least 2.
- `TX_DATA_ADDR`, 32'h0000_03f0: write-only transmit data address.
- `TX_STAT_ADDR`, 32'h0000_03f4: status address. Reads return status; writes clear overflow.
- `clock`  in  1: single clock. All state changes on its rising edge.
- `reset_n`  in  1: synchronous, active-low reset.
- `rw_addr`  in  32: data-bus address from the CPU.
- `w_data`  in  32: store data. Only bits [7:0] are used.
- `w_en`  in  1: store strobe.
- `r_data`  out  32: combinational status word when `rw_addr == TX_STAT_ADDR`, otherwise 0.
- `hit`  out  1: combinational, high when `rw_addr` equals either address.
- `tx`  out  1: serial output, registered. Idle level is 1.

## Operation
- **Push:** a push happens when `w_en` is high and `rw_addr == TX_DATA_ADDR`. It writes `w_data[7:0]` to the FIFO tail.
  - The push is accepted if count < `FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overflow` is set (sticky).
- **Overflow clear:** any write with `w_en` high and `rw_addr == TX_STAT_ADDR` clears `overflow`. If a drop happens in the same cycle, set wins over clear.
- **Status word:**
  - bit0 `busy`: state is not IDLE.
  - bit1 `full`.
  - bit2 `empty`.
  - bit3 `overflow`.
  - bits[11:8] `count` (width `$clog2(FIFO_DEPTH)+1`, zero-extended).
  - All other bits are 0.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: `tx` = 1. If the FIFO is not empty, pop the head into the shift register, go to START, and drive `tx` = 0.
  - START: hold for `CLKS_PER_BIT` cycles, then go to DATA and drive bit 0.
  - DATA: send 8 bits LSB first, `CLKS_PER_BIT` cycles each. A 3-bit index counts 0..7. After bit 7, go to STOP with `tx` = 1.
  - STOP: hold for `CLKS_PER_BIT` cycles. Then, if the FIFO is not empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- **Bit timer:** counts 0..`CLKS_PER_BIT`-1 and reloads to 0 on every state or bit transition. Width is `$clog2(CLKS_PER_BIT)`.
- **Frame length:** exactly 10·`CLKS_PER_BIT` cycles.
- **Count update:** a simultaneous push and pop leaves count unchanged.
- **Pointer wrap:** pointers wrap modulo `FIFO_DEPTH`.

## Timing
- **Reset values:** while `reset_n` = 0 at a rising edge:
  - `tx` = 1 and state = IDLE.
  - FIFO pointers and count = 0, `overflow` = 0, bit timer and bit index = 0.
- **Reset mid-frame:** the frame is aborted and `tx` is high after that edge. FIFO contents are discarded.
- **Write-to-start latency:** push at edge E makes count = 1 after E. The FSM pops at edge E+1, and `tx` falls after edge E+1.
- **Status visibility:** `r_data` and `hit` are combinational, so status reads reflect the state registered at the previous edge.
- **Flags after push:** `full` and `empty` are updated in the cycle after the push edge.
- **Back-to-back frames:** the last STOP cycle of frame n is immediately followed by the START of frame n+1.

## Structure
- **Package `uart_pkg`:**
  - state enum (IDLE, START, DATA, STOP);
  - status bit index constants (`ST_BUSY`=0, `ST_FULL`=1, `ST_EMPTY`=2, `ST_OVF`=3, `ST_CNT_LSB`=8);
  - default address constants.
- **Sub-module `sync_fifo`:** parameterized width and depth, with ports `push`, `pop`, `din`, `dout`, `full`, `empty`, `count`, using the same clock and reset. Its `dout` shows the head combinationally.
- The FSM, bit timer, shift register, overflow flag and address decode live in `uart_tx_mmio`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=8 unless noted.
1. **Reset:** hold `reset_n`=0 for 3 cycles, then release → `tx`=1; a read at 0x3f4 gives `r_data`=32'h0000_0004 and `hit`=1. A read at 0x3fc gives `hit`=0 and `r_data`=0.
2. **Single byte:** store 0x55 to 0x3f0 at edge E → `tx` falls after E+1. The 40-cycle sequence is 0,1,0,1,0,1,0,1,0,1, four cycles per bit. `busy`=1 throughout, then IDLE with status 0x4.
3. **Back-to-back:** store 0xA5, 0x0F, 0xFF on consecutive cycles → 120 contiguous cycles of three frames with no idle cycle between them. `count` peaks at 2.
4. **Overflow:** store 10 bytes 0x00..0x09 on consecutive cycles → 0x00 is popped at E+1, 0x01..0x08 fill the FIFO, and 0x09 is dropped. `full`=1, `overflow`=1, and exactly 9 frames 0x00..0x08 are transmitted.
5. **Clear and edge cases:**
   - Store to 0x3f4 → `overflow` clears.
   - Push on the same edge as a STOP-to-START pop with the FIFO full → push is accepted and `count` is unchanged.
   - Clear on the same edge as a drop → `overflow` stays 1.
6. **Reset mid-frame:** assert `reset_n`=0 during DATA bit 3 with 2 bytes queued → `tx`=1 after the edge, status 0x4, and no further frames after release.
